// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet-5 fixed-point datapath.
// Word format, layer sizes and the fully-connected stage state encoding.
package lenet_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FRAC_BITS  = 8;

    localparam int C5_IN  = 400;
    localparam int C5_OUT = 120;

    // Largest positive word; ReLU output saturates here.
    localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        WRITE,
        DONE
    } fc_state_t;

endpackage

// File: rtl/fc_mac.sv
// Signed multiply register followed by an accumulator; a first beat reloads
// the accumulator with the scaled bias so no separate clear cycle is needed.
module fc_mac #(
    parameter int DATA_WIDTH = lenet_pkg::DATA_WIDTH,
    parameter int FRAC_BITS  = lenet_pkg::FRAC_BITS,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_vld,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    input  logic signed [DATA_WIDTH-1:0] bias,
    output logic signed [ACC_WIDTH-1:0]  acc,
    output logic                         last_acc
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0]        prod;
    logic                        prod_vld;
    logic                        prod_first;
    logic                        prod_last;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] bias_ext;

    // Size casts of signed operands sign-extend.
    assign prod_ext = ACC_WIDTH'(prod);
    assign bias_ext = ACC_WIDTH'(bias) <<< FRAC_BITS;

    // NOTE: the datapath registers are reset too, so an aborted run leaves no
    // stale product or partial sum for the next start to pick up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod       <= '0;
            prod_vld   <= 1'b0;
            prod_first <= 1'b0;
            prod_last  <= 1'b0;
            acc        <= '0;
        end else begin
            prod_vld   <= in_vld;
            prod_first <= in_vld & in_first;
            prod_last  <= in_vld & in_last;
            if (in_vld) begin
                prod <= PW'(a) * PW'(b);
            end
            if (prod_vld) begin
                acc <= prod_first ? (bias_ext + prod_ext) : (acc + prod_ext);
            end
        end
    end

    // High in the cycle the final product of a neuron is being added.
    assign last_acc = prod_vld & prod_last;

endmodule

// File: rtl/fc_layer5.sv
// C5 fully-connected stage: streams pooled features against the weight ROM,
// adds the neuron bias, applies ReLU with saturation and writes one word per neuron.
module fc_layer5 #(
    parameter int DATA_WIDTH = lenet_pkg::DATA_WIDTH,
    parameter int FRAC_BITS  = lenet_pkg::FRAC_BITS,
    parameter int IN_LEN     = lenet_pkg::C5_IN,
    parameter int OUT_LEN    = lenet_pkg::C5_OUT,
    parameter int ACC_WIDTH  = 40,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [8:0]            feat_addr,
    input  logic [DATA_WIDTH-1:0] feat_dout,
    output logic [15:0]           w_addr,
    input  logic [DATA_WIDTH-1:0] w_dout,
    output logic [6:0]            b_addr,
    input  logic [DATA_WIDTH-1:0] b_dout,
    output logic                  out_we,
    output logic [6:0]            out_addr,
    output logic [DATA_WIDTH-1:0] out_din,
    output logic                  busy,
    output logic                  done
);

    import lenet_pkg::fc_state_t;
    import lenet_pkg::IDLE;
    import lenet_pkg::ISSUE;
    import lenet_pkg::DRAIN;
    import lenet_pkg::WRITE;
    import lenet_pkg::DONE;
    import lenet_pkg::MAX_POS;

    localparam logic [8:0] I_LAST = 9'(IN_LEN - 1);
    localparam logic [6:0] N_LAST = 7'(OUT_LEN - 1);

    fc_state_t state_q;
    fc_state_t state_d;

    logic [8:0]  i_q;
    logic [6:0]  n_q;
    logic [15:0] w_q;
    logic        issue;

    logic [RD_LAT-1:0] vld_sr;
    logic [RD_LAT-1:0] first_sr;
    logic [RD_LAT-1:0] last_sr;

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] r;
    logic                        last_acc;
    logic [DATA_WIDTH-1:0]       sat;

    // NOTE: state and counters use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        out_we    = 1'b0;
        feat_addr = '0;
        w_addr    = '0;
        b_addr    = '0;
        out_addr  = '0;
        out_din   = '0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = ISSUE;
            end
            ISSUE: begin
                busy      = 1'b1;
                issue     = 1'b1;
                feat_addr = i_q;
                w_addr    = w_q;
                b_addr    = n_q;
                if (i_q == I_LAST) state_d = DRAIN;
            end
            DRAIN: begin
                busy   = 1'b1;
                b_addr = n_q;
                if (last_acc) state_d = WRITE;
            end
            WRITE: begin
                busy     = 1'b1;
                out_we   = 1'b1;
                out_addr = n_q;
                out_din  = sat;
                state_d  = (n_q == N_LAST) ? DONE : ISSUE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // w_q runs continuously across neurons, so it always equals n*IN_LEN + i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= '0;
            n_q <= '0;
            w_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        i_q <= '0;
                        n_q <= '0;
                        w_q <= '0;
                    end
                end
                ISSUE: begin
                    i_q <= (i_q == I_LAST) ? 9'd0 : i_q + 9'd1;
                    w_q <= w_q + 16'd1;
                end
                WRITE: begin
                    i_q <= '0;
                    if (n_q != N_LAST) n_q <= n_q + 7'd1;
                end
                default: ;
            endcase
        end
    end

    // Tags travel alongside the read so the MAC sees them with the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr   <= '0;
            first_sr <= '0;
            last_sr  <= '0;
        end else begin
            vld_sr[0]   <= issue;
            first_sr[0] <= issue & (i_q == 9'd0);
            last_sr[0]  <= issue & (i_q == I_LAST);
            for (int k = 1; k < RD_LAT; k++) begin
                vld_sr[k]   <= vld_sr[k-1];
                first_sr[k] <= first_sr[k-1];
                last_sr[k]  <= last_sr[k-1];
            end
        end
    end

    fc_mac #(
        .DATA_WIDTH(DATA_WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (vld_sr[RD_LAT-1]),
        .in_first(first_sr[RD_LAT-1]),
        .in_last (last_sr[RD_LAT-1]),
        .a       (feat_dout),
        .b       (w_dout),
        .bias    (b_dout),
        .acc     (acc),
        .last_acc(last_acc)
    );

    // Floor to the word grid, then clamp to [0, MAX_POS].
    assign r = acc >>> FRAC_BITS;

    always_comb begin
        sat = r[DATA_WIDTH-1:0];
        if (r[ACC_WIDTH-1]) begin
            sat = '0;
        end else if (|r[ACC_WIDTH-2:DATA_WIDTH-1]) begin
            sat = MAX_POS;
        end
    end

endmodule

// File: tb/tb_fc_layer5.sv
// Bench for fc_layer5: a full-size instance and a shrunken 4x3 instance, each fed
// by RD_LAT=2 memory models, checked against a reference model through scoreboards.
module tb_fc_layer5;

    localparam int A_IN  = 400;
    localparam int A_OUT = 120;
    localparam int B_IN  = 4;
    localparam int B_OUT = 3;

    typedef struct {
        logic [6:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_a;
    logic start_b;
    int   mode;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0]  a_feat_addr, b_feat_addr;
    logic [15:0] a_feat_dout, b_feat_dout;
    logic [15:0] a_w_addr, b_w_addr;
    logic [15:0] a_w_dout, b_w_dout;
    logic [6:0]  a_b_addr, b_b_addr;
    logic [15:0] a_b_dout, b_b_dout;
    logic        a_out_we, b_out_we;
    logic [6:0]  a_out_addr, b_out_addr;
    logic [15:0] a_out_din, b_out_din;
    logic        a_busy, b_busy;
    logic        a_done, b_done;

    fc_layer5 dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .feat_addr(a_feat_addr), .feat_dout(a_feat_dout),
        .w_addr(a_w_addr), .w_dout(a_w_dout),
        .b_addr(a_b_addr), .b_dout(a_b_dout),
        .out_we(a_out_we), .out_addr(a_out_addr), .out_din(a_out_din),
        .busy(a_busy), .done(a_done)
    );

    fc_layer5 #(.IN_LEN(B_IN), .OUT_LEN(B_OUT)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .feat_addr(b_feat_addr), .feat_dout(b_feat_dout),
        .w_addr(b_w_addr), .w_dout(b_w_dout),
        .b_addr(b_b_addr), .b_dout(b_b_dout),
        .out_we(b_out_we), .out_addr(b_out_addr), .out_din(b_out_din),
        .busy(b_busy), .done(b_done)
    );

    // Memory contents per test mode:
    // 0 weights 0 / bias 1.0, 1 features 1.0 / weights 1 LSB, 2 all 0x7FFF,
    // 3 features 1.0 / weights -1.0, 4 signed ramps.
    function automatic logic [15:0] feat_val(input logic [8:0] a);
        case (mode)
            1, 3:    return 16'h0100;
            2:       return 16'h7FFF;
            default: return 16'((int'(a) * 173) % 2048 - 1024);
        endcase
    endfunction

    function automatic logic [15:0] w_val(input logic [15:0] a);
        case (mode)
            0:       return 16'h0000;
            1:       return 16'h0001;
            2:       return 16'h7FFF;
            3:       return 16'hFF00;
            default: return 16'((int'(a) * 89) % 1024 - 400);
        endcase
    endfunction

    function automatic logic [15:0] b_val(input logic [6:0] a);
        case (mode)
            0:       return 16'h0100;
            1, 3:    return 16'h0000;
            2:       return 16'h7FFF;
            default: return 16'(int'(a) * 300 - 200);
        endcase
    endfunction

    // Reference: Q8.8 x Q8.8 sums are Q16.16; floor back to Q8.8, clamp to [0, 0x7FFF].
    // Mode 1 gives 400 * (1.0 * 1/256) = 1.5625 = 0x0190.
    function automatic logic [15:0] model(input int n, input int len);
        logic signed [15:0] f, w, b;
        longint acc, r;
        b   = b_val(7'(n));
        acc = longint'(b) * 256;
        for (int i = 0; i < len; i++) begin
            f   = feat_val(9'(i));
            w   = w_val(16'(n * len + i));
            acc = acc + longint'(f) * longint'(w);
        end
        r = acc >>> 8;
        if (r < 0) return 16'h0000;
        if (r > 32767) return 16'h7FFF;
        return 16'(r);
    endfunction

    // Memories: address registered on one edge, data registered on the next.
    logic [8:0]  a_fa_q, b_fa_q;
    logic [15:0] a_wa_q, b_wa_q;
    logic [6:0]  a_ba_q, b_ba_q;

    always @(posedge clk) begin
        a_fa_q      <= a_feat_addr;
        a_wa_q      <= a_w_addr;
        a_ba_q      <= a_b_addr;
        a_feat_dout <= feat_val(a_fa_q);
        a_w_dout    <= w_val(a_wa_q);
        a_b_dout    <= b_val(a_ba_q);
        b_fa_q      <= b_feat_addr;
        b_wa_q      <= b_w_addr;
        b_ba_q      <= b_b_addr;
        b_feat_dout <= feat_val(b_fa_q);
        b_w_dout    <= w_val(b_wa_q);
        b_b_dout    <= b_val(b_ba_q);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] a_outs();
        return 64'({a_busy, a_done, a_out_we, a_out_addr, a_out_din, a_feat_addr, a_w_addr, a_b_addr});
    endfunction

    function automatic logic [63:0] b_outs();
        return 64'({b_busy, b_done, b_out_we, b_out_addr, b_out_din, b_feat_addr, b_w_addr, b_b_addr});
    endfunction

    // Scoreboards and monitors, sampled on the falling edge.
    wr_t sb_a[$];
    wr_t sb_b[$];
    wr_t e_a, e_b;
    int  wr_a = 0, wr_b = 0, done_a = 0, done_b = 0;
    time t_done_a, t_done_b;
    time we_t_b[$];
    int  seen_b[16];
    int  wmax_b;

    always @(negedge clk) begin
        if (a_out_we) begin
            wr_a++;
            if (sb_a.size() != 0) begin
                e_a = sb_a.pop_front();
                check("a_out_addr", 64'(a_out_addr), 64'(e_a.addr));
                check("a_out_din", 64'(a_out_din), 64'(e_a.data));
            end else begin
                check("a_unexpected_we", 64'(a_out_we), 64'(0));
            end
        end
        if (a_done) begin
            done_a++;
            t_done_a = $time;
        end
        if (b_out_we) begin
            wr_b++;
            we_t_b.push_back($time);
            if (sb_b.size() != 0) begin
                e_b = sb_b.pop_front();
                check("b_out_addr", 64'(b_out_addr), 64'(e_b.addr));
                check("b_out_din", 64'(b_out_din), 64'(e_b.data));
            end else begin
                check("b_unexpected_we", 64'(b_out_we), 64'(0));
            end
        end
        if (b_done) begin
            done_b++;
            t_done_b = $time;
        end
        if (b_busy) begin
            if (int'(b_w_addr) > wmax_b) wmax_b = int'(b_w_addr);
            seen_b[b_w_addr[3:0]] = 1;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start_a(output time t0);
        @(negedge clk);
        t0 = $time;
        #1 start_a = 1'b1;
        @(negedge clk);
        #1 start_a = 1'b0;
    endtask

    task automatic pulse_start_b(output time t0);
        @(negedge clk);
        t0 = $time;
        #1 start_b = 1'b1;
        @(negedge clk);
        #1 start_b = 1'b0;
    endtask

    task automatic wait_writes_a(input int target, input int budget);
        int k = 0;
        while (wr_a < target && k < budget) begin
            step();
            k++;
        end
        check("a_write_count", 64'(wr_a), 64'(target));
    endtask

    task automatic wait_done_a(input int budget);
        int base = done_a;
        int k = 0;
        while (done_a == base && k < budget) begin
            step();
            k++;
        end
        check("a_done_seen", 64'(done_a - base), 64'(1));
    endtask

    task automatic wait_done_b(input int budget);
        int base = done_b;
        int k = 0;
        while (done_b == base && k < budget) begin
            step();
            k++;
        end
        check("b_done_seen", 64'(done_b - base), 64'(1));
    endtask

    task automatic push_exp_a();
        sb_a.delete();
        for (int n = 0; n < A_OUT; n++) sb_a.push_back('{7'(n), model(n, A_IN)});
    endtask

    // Reset between falling and rising edge; outputs must clear asynchronously.
    task automatic abort_a(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        sb_a.delete();
        #1 check(tag, a_outs(), 64'(0));
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic run_a_partial(input int m, input int nw);
        time t0;
        mode = m;
        push_exp_a();
        pulse_start_a(t0);
        wait_writes_a(wr_a + nw, nw * (A_IN + 4) + 20);
        abort_a("a_abort_outs");
    endtask

    initial begin
        time t0, t1;
        int  base_w, base_d, distinct;
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        mode    = 4;
        repeat (3) step();
        check("a_reset_outs", a_outs(), 64'(0));
        check("b_reset_outs", b_outs(), 64'(0));
        rst_n = 1'b1;
        repeat (3) step();
        check("a_idle_outs", a_outs(), 64'(0));
        check("b_idle_outs", b_outs(), 64'(0));

        // Small instance: ramp data, a second start mid-run must be ignored.
        mode = 4;
        sb_b.delete();
        we_t_b.delete();
        wmax_b = 0;
        for (int k = 0; k < 16; k++) seen_b[k] = 0;
        for (int n = 0; n < B_OUT; n++) sb_b.push_back('{7'(n), model(n, B_IN)});
        base_w = wr_b;
        base_d = done_b;
        pulse_start_b(t0);
        check("b_busy_after_start", 64'(b_busy), 64'(1));
        repeat (8) step();
        pulse_start_b(t1);
        wait_done_b(100);
        check("b_latency", 64'((t_done_b - t0) / 10), 64'(B_OUT * (B_IN + 4) + 1));
        check("b_writes", 64'(wr_b - base_w), 64'(B_OUT));
        check("b_sb_empty", 64'(sb_b.size()), 64'(0));
        if (we_t_b.size() == 3) begin
            check("b_we_gap0", 64'((we_t_b[1] - we_t_b[0]) / 10), 64'(8));
            check("b_we_gap1", 64'((we_t_b[2] - we_t_b[1]) / 10), 64'(8));
        end
        check("b_w_addr_max", 64'(wmax_b), 64'(11));
        distinct = 0;
        for (int k = 0; k < 16; k++) distinct += seen_b[k];
        check("b_w_addr_distinct", 64'(distinct), 64'(12));
        repeat (5) step();
        check("b_done_pulses", 64'(done_b - base_d), 64'(1));
        check("b_idle_after_run", b_outs(), 64'(0));

        // Full-size instance, first three neurons of each constant pattern.
        run_a_partial(1, 3);
        run_a_partial(2, 3);
        run_a_partial(3, 3);

        // Reset in the middle of neuron 5: no further writes, no done.
        mode = 4;
        push_exp_a();
        base_w = wr_a;
        base_d = done_a;
        pulse_start_a(t0);
        wait_writes_a(base_w + 5, 5 * (A_IN + 4) + 20);
        repeat (100) step();
        check("a_busy_mid_n5", 64'(a_busy), 64'(1));
        check("a_b_addr_mid_n5", 64'(a_b_addr), 64'(5));
        abort_a("a_rst_mid_outs");
        repeat (500) step();
        check("a_writes_after_rst", 64'(wr_a - base_w), 64'(5));
        check("a_done_after_rst", 64'(done_a - base_d), 64'(0));
        check("a_idle_after_rst", a_outs(), 64'(0));

        // Fresh full run: every neuron passes its bias of 1.0 straight through.
        mode = 0;
        push_exp_a();
        base_w = wr_a;
        pulse_start_a(t0);
        check("a_busy_after_start", 64'(a_busy), 64'(1));
        wait_done_a(A_OUT * (A_IN + 4) + 100);
        check("a_latency", 64'((t_done_a - t0) / 10), 64'(48481));
        check("a_writes_full", 64'(wr_a - base_w), 64'(A_OUT));
        check("a_sb_empty", 64'(sb_a.size()), 64'(0));
        step();
        check("a_idle_after_run", a_outs(), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
